// File: rtl/frame_buffer.sv
// ---------------------------------------------------------------------------
// frame_buffer
// Double-buffered 1-bit framebuffer. The GPU rasteriser writes into the back
// bank while display scan-out reads the front bank. A requested bank swap
// waits for the start of vertical blanking. After a swap, the new back bank
// can be sweep-cleared; draw_ready is low while that clear runs.
//
// State table:
//   state       | meaning
//   ST_IDLE     | GPU writes accepted, waiting for swap_req / vsync_start
//   ST_CLEARING | sweeping CLEAR_COLOR through the back bank, GPU held off
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ce                    enable for the write/clear/swap logic (not the read port)
//   wr_en/wr_addr/wr_data GPU pixel write into the back bank
//   draw_ready            high when GPU writes are accepted
//   swap_req              pulse: back bank complete, swap at next vsync_start
//   vsync_start           pulse: first blanking line
//   swap_done             one-cycle pulse in the cycle front_sel toggles
//   front_sel             bank currently displayed
//   rd_en/rd_addr/rd_data registered front-bank read
// ---------------------------------------------------------------------------
module frame_buffer #(
    parameter int   HOR_ACTIVE_PIXELS = 640,
    parameter int   VER_ACTIVE_PIXELS = 480,
    parameter bit   CLEAR_ON_SWAP     = 1'b1,
    parameter logic CLEAR_COLOR       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        wr_en,
    input  logic [20:0] wr_addr,
    input  logic        wr_data,
    output logic        draw_ready,
    input  logic        swap_req,
    input  logic        vsync_start,
    output logic        swap_done,
    output logic        front_sel,
    input  logic        rd_en,
    input  logic [20:0] rd_addr,
    output logic        rd_data
);

    localparam int          DEPTH  = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [20:0] DEPTH_A = 21'(DEPTH);
    localparam logic [20:0] LAST_A  = 21'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } state_t;

    state_t      state_q, state_d;
    logic        swap_pending_q, swap_pending_d;
    logic [20:0] clr_addr_q, clr_addr_d;
    logic        swap_fire;
    logic        clr_we;

    logic        gpu_we;
    logic        mem_we;
    logic [AW-1:0] mem_idx;
    logic        mem_bit;
    logic        back_sel;

    logic        bank0 [DEPTH];
    logic        bank1 [DEPTH];

    // -----------------------------------------------------------------------
    // Swap / clear controller
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        swap_pending_d = swap_pending_q;
        clr_addr_d     = clr_addr_q;
        swap_fire      = 1'b0;
        clr_we         = 1'b0;

        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    // A swap_req coinciding with vsync_start swaps immediately.
                    if (vsync_start && (swap_pending_q || swap_req)) begin
                        swap_fire      = 1'b1;
                        swap_pending_d = 1'b0;
                        if (CLEAR_ON_SWAP) begin
                            state_d = ST_CLEARING;
                        end
                    end else if (swap_req) begin
                        swap_pending_d = 1'b1;
                    end
                end
                ST_CLEARING: begin
                    // vsync_start is ignored here; a pending swap waits for
                    // the next blanking interval after the sweep.
                    clr_we = 1'b1;
                    if (swap_req) begin
                        swap_pending_d = 1'b1;
                    end
                    if (clr_addr_q == LAST_A) begin
                        clr_addr_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + 21'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            swap_pending_q <= 1'b0;
            clr_addr_q     <= '0;
            front_sel      <= 1'b0;
            swap_done      <= 1'b0;
            draw_ready     <= 1'b0;
        end else begin
            state_q        <= state_d;
            swap_pending_q <= swap_pending_d;
            clr_addr_q     <= clr_addr_d;
            front_sel      <= front_sel ^ swap_fire;
            swap_done      <= swap_fire;
            // Registered so it falls in the same cycle front_sel toggles
            // and rises once the last clear write has been made.
            draw_ready     <= (state_d == ST_IDLE);
        end
    end

    // -----------------------------------------------------------------------
    // Back-bank write port: GPU pixels in IDLE, clear sweep in CLEARING.
    // The two sources never overlap because draw_ready is low while clearing.
    // -----------------------------------------------------------------------
    assign back_sel = ~front_sel;
    assign gpu_we   = ce && draw_ready && wr_en && (wr_addr < DEPTH_A);
    assign mem_we   = gpu_we || clr_we;
    assign mem_idx  = clr_we ? clr_addr_q[AW-1:0] : wr_addr[AW-1:0];
    assign mem_bit  = clr_we ? CLEAR_COLOR : wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (back_sel) begin
                bank1[mem_idx] <= mem_bit;
            end else begin
                bank0[mem_idx] <= mem_bit;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Front-bank read port, independent of ce. Using the registered front_sel
    // means a read issued in a swap cycle still sees the old front bank.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 1'b0;
        end else if (rd_en) begin
            if (rd_addr < DEPTH_A) begin
                rd_data <= front_sel ? bank1[rd_addr[AW-1:0]] : bank0[rd_addr[AW-1:0]];
            end else begin
                rd_data <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer
// Directed test of frame_buffer with a 4x2 (8-pixel) bank and clear-on-swap.
// ---------------------------------------------------------------------------
module tb_frame_buffer;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        wr_en;
    logic [20:0] wr_addr;
    logic        wr_data;
    logic        draw_ready;
    logic        swap_req;
    logic        vsync_start;
    logic        swap_done;
    logic        front_sel;
    logic        rd_en;
    logic [20:0] rd_addr;
    logic        rd_data;

    int n_chk;
    int n_fail;

    frame_buffer #(
        .HOR_ACTIVE_PIXELS (4),
        .VER_ACTIVE_PIXELS (2),
        .CLEAR_ON_SWAP     (1'b1),
        .CLEAR_COLOR       (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .draw_ready  (draw_ready),
        .swap_req    (swap_req),
        .vsync_start (vsync_start),
        .swap_done   (swap_done),
        .front_sel   (front_sel),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [20:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic wr(input logic [20:0] a, input logic d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // swap_req pulse followed by vsync_start pulse; returns after the swap edge
    task automatic swap_seq();
        swap_req = 1'b1;
        tick();
        swap_req    = 1'b0;
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (!draw_ready && n < 100) begin
            tick();
            n++;
        end
        chk("clear_done", {31'd0, draw_ready}, 32'd1);
    endtask

    initial begin
        int low_cnt;
        int early;
        n_chk  = 0;
        n_fail = 0;
        rst_n = 1'b0; ce = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
        swap_req = 1'b0; vsync_start = 1'b0; rd_en = 1'b0; rd_addr = '0;

        // reset state
        #12;
        chk("rst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("rst_draw_ready", {31'd0, draw_ready}, 32'd0);
        chk("rst_swap_done", {31'd0, swap_done}, 32'd0);
        chk("rst_rd_data", {31'd0, rd_data}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("draw_ready_after_rst", {31'd0, draw_ready}, 32'd1);

        // swap A: pending request, then vsync; measure clear length and
        // try GPU writes to addr 1 throughout the clear (must be dropped)
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("a_no_swap_on_req", {31'd0, front_sel}, 32'd0);
        chk("a_no_done_on_req", {31'd0, swap_done}, 32'd0);
        tick();
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        chk("a_swap_done", {31'd0, swap_done}, 32'd1);
        chk("a_front_sel", {31'd0, front_sel}, 32'd1);
        low_cnt = 0;
        if (!draw_ready) low_cnt = 1;
        wr_en = 1'b1; wr_addr = 21'd1; wr_data = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) chk("a_done_one_cycle", {31'd0, swap_done}, 32'd0);
            if (draw_ready) break;
            low_cnt++;
        end
        wr_en = 1'b0;
        chk("a_clear_len", low_cnt, 32'd8);

        // swap B: swap_req and vsync_start together swap immediately
        swap_req = 1'b1; vsync_start = 1'b1;
        tick();
        swap_req = 1'b0; vsync_start = 1'b0;
        chk("b_swap_done", {31'd0, swap_done}, 32'd1);
        chk("b_front_sel", {31'd0, front_sel}, 32'd0);
        wait_clear();
        // front bank 0 was fully cleared; addr 1 shows the GPU write was dropped
        for (int a = 0; a < 8; a++) begin
            rd(21'(a));
            chk($sformatf("cleared_%0d", a), {31'd0, rd_data}, 32'd0);
        end

        // write to back bank, not visible until swapped
        wr(21'd5, 1'b1);
        rd(21'd5);
        chk("back_not_visible", {31'd0, rd_data}, 32'd0);
        swap_seq();
        chk("t1_front_sel", {31'd0, front_sel}, 32'd1);
        wait_clear();
        rd(21'd5);
        chk("t1_rd5", {31'd0, rd_data}, 32'd1);
        tick();
        chk("t1_rd_hold", {31'd0, rd_data}, 32'd1);
        rd(21'd4);
        chk("t1_rd4", {31'd0, rd_data}, 32'd0);
        rd(21'd5);
        rd(21'd8);
        chk("rd_out_of_range", {31'd0, rd_data}, 32'd0);

        // long gap between swap_req and vsync_start
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("gap_no_toggle_req", {31'd0, front_sel}, 32'd1);
        early = 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (swap_done || front_sel != 1'b1) early++;
        end
        chk("gap_no_early_swap", early, 32'd0);
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        chk("gap_swap_done", {31'd0, swap_done}, 32'd1);
        chk("gap_front_sel", {31'd0, front_sel}, 32'd0);
        tick();
        chk("gap_done_pulse", {31'd0, swap_done}, 32'd0);
        wait_clear();

        // two swap_req pulses, one vsync: exactly one toggle
        swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        vsync_start = 1'b1; tick(); vsync_start = 1'b0;
        chk("dbl_front_sel", {31'd0, front_sel}, 32'd1);
        wait_clear();
        vsync_start = 1'b1; tick(); vsync_start = 1'b0;
        chk("dbl_no_second_swap", {31'd0, front_sel}, 32'd1);
        chk("dbl_no_second_done", {31'd0, swap_done}, 32'd0);

        // vsync during clear is ignored; pending swap waits for next vsync
        swap_seq();
        chk("clrv_front_sel", {31'd0, front_sel}, 32'd0);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        vsync_start = 1'b1; tick(); vsync_start = 1'b0;
        chk("clrv_ignored", {31'd0, front_sel}, 32'd0);
        wait_clear();
        vsync_start = 1'b1; tick(); vsync_start = 1'b0;
        chk("clrv_pending_swap", {31'd0, front_sel}, 32'd1);
        wait_clear();

        // back is bank 0 (cleared). ce low blocks writes and swaps,
        // wr_addr = DEPTH is dropped (would alias addr 0 otherwise)
        wr(21'd0, 1'b1);
        ce = 1'b0;
        wr(21'd2, 1'b1);
        ce = 1'b1;
        wr(21'd8, 1'b0);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        ce = 1'b0; vsync_start = 1'b1; tick(); vsync_start = 1'b0; ce = 1'b1;
        chk("ce_low_no_swap", {31'd0, front_sel}, 32'd1);
        chk("ce_low_no_done", {31'd0, swap_done}, 32'd0);
        vsync_start = 1'b1; tick(); vsync_start = 1'b0;
        chk("ce_swap_after", {31'd0, front_sel}, 32'd0);
        wait_clear();
        rd(21'd0);
        chk("oob_wr_addr0_kept", {31'd0, rd_data}, 32'd1);
        rd(21'd2);
        chk("ce_low_wr_dropped", {31'd0, rd_data}, 32'd0);

        // reset in the middle of a clear
        swap_seq();
        chk("mid_front_sel", {31'd0, front_sel}, 32'd1);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("mid_rst_draw_ready", {31'd0, draw_ready}, 32'd0);
        chk("mid_rst_swap_done", {31'd0, swap_done}, 32'd0);
        chk("mid_rst_rd_data", {31'd0, rd_data}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("mid_rel_draw_ready", {31'd0, draw_ready}, 32'd1);
        tick(); tick(); tick();
        chk("mid_no_resume", {31'd0, draw_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
Double-buffered 1-bit framebuffer that sits directly downstream of the GPU rasteriser. It consumes the rasteriser's per-pixel write stream (wr_en/wr_addr/wr_data) into the back bank, while the display scan-out reads the front bank. Bank swap is requested by the frame controller once the GPU has drained its op FIFO, and takes effect only at the start of vertical blanking. After a swap, the new back bank is optionally cleared. While clearing, draw_ready is deasserted; the top level ANDs draw_ready into the GPU's ce.

Parameters:
HOR_ACTIVE_PIXELS, 640, visible pixels per line.
VER_ACTIVE_PIXELS, 480, visible lines; DEPTH = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS pixels per bank.
CLEAR_ON_SWAP, 1, 1 = sweep-clear the new back bank after every swap; 0 = no clear.
CLEAR_COLOR, 1'b0, pixel value written during a clear.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable for the write/clear/swap logic; the read port ignores it
wr_en  in  1  GPU pixel write strobe
wr_addr  in  21  GPU linear pixel address, y*HOR_ACTIVE_PIXELS+x
wr_data  in  1  GPU pixel value
draw_ready  out  1  high = GPU writes are accepted; low during clear
swap_req  in  1  single-cycle pulse from frame controller: back bank complete
vsync_start  in  1  single-cycle pulse at first blanking line
swap_done  out  1  single-cycle pulse in the cycle the bank select toggles
front_sel  out  1  bank currently being displayed
rd_en  in  1  display read strobe
rd_addr  in  21  display linear pixel address
rd_data  out  1  front-bank pixel, registered

Behaviour:
- Storage: two banks of DEPTH x 1 bit, inferred block RAM. Contents are not reset.
- Reset (rst_n low, async): state=IDLE, front_sel=0, swap_pending=0, clr_addr=0, draw_ready=0 until the first clk edge after release (then 1), swap_done=0, rd_data=0.
- Read port: runs every cycle regardless of ce. If rd_en=1, rd_data takes bank[front_sel][rd_addr] one cycle later; otherwise rd_data holds. rd_addr>=DEPTH returns 0.
  - A read issued in the same cycle as a swap uses the pre-swap front_sel.
- Write port: when ce=1, draw_ready=1 and wr_en=1, write wr_data to bank[~front_sel][wr_addr]. wr_addr>=DEPTH is dropped silently. Writes arriving while draw_ready=0 are dropped.
- Read and write always target different banks, so there is never a read/write collision.
- All state below advances only when ce=1; vsync_start and swap_req are sampled only when ce=1.
- State machine:
  - IDLE: draw_ready=1.
    - swap_req sets swap_pending.
    - If vsync_start and (swap_pending or swap_req): toggle front_sel and pulse swap_done. swap_req and vsync_start in the same cycle swap immediately. Clear swap_pending. Go to CLEARING if CLEAR_ON_SWAP, else stay in IDLE.
    - vsync_start without a pending request: no action.
  - CLEARING: draw_ready=0.
    - Each ce cycle, write CLEAR_COLOR to bank[~front_sel][clr_addr] and increment clr_addr.
    - At clr_addr==DEPTH-1, write that last address, reset clr_addr to 0 and go to IDLE. The clear therefore takes exactly DEPTH ce-cycles.
    - swap_req during CLEARING sets swap_pending.
    - vsync_start during CLEARING is ignored; the pending swap waits for the next vsync_start after the clear completes.
- swap_done is high for exactly one cycle per swap, registered (asserted the cycle after the triggering edge, same cycle front_sel changes).
- A second swap_req while swap_pending=1 is absorbed: at most one swap happens per vsync_start.
- Reset mid-clear abandons the clear. The back bank is left partially cleared; the GPU redraws the full scene anyway.

Test Plan:
- Reset then write: wr_addr=0x00005, wr_data=1 with ce=1 → no visible change to reads (back bank). Then swap_req, vsync_start, and wait for clear to finish → front_sel=1, and reading rd_addr=5 gives rd_data=1 one cycle after rd_en.
- swap_req at cycle 10, vsync_start at cycle 50 → swap_done pulses once at cycle 51; front_sel toggles at cycle 51; no toggle at cycle 11.
- CLEAR_ON_SWAP=1, HOR=4, VER=2 → draw_ready is low for exactly 8 ce-cycles after the swap. Every back-bank address reads CLEAR_COLOR after the next swap. A GPU write issued during the clear is dropped.
- swap_req and vsync_start asserted in the same cycle → immediate swap. Two swap_req pulses before one vsync_start → exactly one toggle.
- ce held low across vsync_start with a pending swap → no swap. wr_addr=DEPTH with wr_en=1 → no write; neighbouring address 0 is unchanged.
- rst_n asserted mid-clear (async, between clock edges) → front_sel=0, draw_ready=0 and swap_done=0 immediately; draw_ready=1 on the first edge after release; the clear does not resume.
